// File: rtl/forward_select_gen_if.sv
// Operand-mux select interface between the hazard controller and the
// ID/EX datapath.
//   master : the forwarding controller (drives selects, stall, count)
//   slave  : the datapath side (drives ID fields and freeze)
// Signals:
//   freeze               global pipeline hold
//   id_valid/id_rs/id_rt/id_dst/id_reg_write/id_mem_read  ID-stage decode
//   fwd_a_sel/fwd_b_sel  registered EX operand mux selects
//   stall                combinational load-use stall request
//   stall_count          saturating count of stall cycles
interface forward_select_gen_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   freeze;
  logic                   id_valid;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic [4:0]             id_dst;
  logic                   id_reg_write;
  logic                   id_mem_read;
  logic [1:0]             fwd_a_sel;
  logic [1:0]             fwd_b_sel;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    input  freeze, id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );

  modport slave (
    output freeze, id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/forward_select_gen.sv
// Forwarding and load-use hazard controller for a 5-stage MIPS pipeline.
// Tracks dst/we/load flags of the instructions in EX, MEM and WB and
// produces registered 2-bit operand mux selects for the instruction in EX
// (00 regfile, 01 MEM/WB result, 10 EX/MEM result) plus a combinational
// load-use stall request.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    forward_select_gen_if.master (ID fields, freeze in; selects,
//          stall, stall_count out)
module forward_select_gen #(
  parameter int STALL_CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  forward_select_gen_if.master bus
);

  logic                   r_ex_valid;
  logic [4:0]             r_ex_rs;
  logic [4:0]             r_ex_rt;
  logic [4:0]             r_ex_dst;
  logic                   r_ex_we;
  logic                   r_ex_mr;
  logic [4:0]             r_mem_dst;
  logic                   r_mem_we;
  logic [4:0]             r_wb_dst;
  logic                   r_wb_we;
  logic [1:0]             r_fwd_a_sel;
  logic [1:0]             r_fwd_b_sel;
  logic [STALL_CNT_W-1:0] r_stall_count;

  logic                   w_stall;
  logic [1:0]             w_next_a;
  logic [1:0]             w_next_b;
  logic                   w_unused_tracking;

  // EX producer beats MEM producer: it is the more recent write of r.
  function automatic logic [1:0] sel_for(input logic [4:0] r);
    if (r == 5'd0)
      return 2'b00;
    if (r_ex_valid && r_ex_we && (r_ex_dst == r))
      return 2'b10;
    if (r_mem_we && (r_mem_dst == r))
      return 2'b01;
    return 2'b00;
  endfunction

  assign w_next_a = sel_for(bus.id_rs);
  assign w_next_b = sel_for(bus.id_rt);

  assign w_stall = bus.id_valid & r_ex_valid & r_ex_mr & r_ex_we &
                   (r_ex_dst != 5'd0) &
                   ((r_ex_dst == bus.id_rs) | (r_ex_dst == bus.id_rt));

  // WB and the EX source fields are kept for pipeline tracking only.
  assign w_unused_tracking = ^{r_ex_rs, r_ex_rt, r_wb_dst, r_wb_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_rs       <= '0;
      r_ex_rt       <= '0;
      r_ex_dst      <= '0;
      r_ex_we       <= 1'b0;
      r_ex_mr       <= 1'b0;
      r_mem_dst     <= '0;
      r_mem_we      <= 1'b0;
      r_wb_dst      <= '0;
      r_wb_we       <= 1'b0;
      r_fwd_a_sel   <= 2'b00;
      r_fwd_b_sel   <= 2'b00;
      r_stall_count <= '0;
    end else if (!bus.freeze) begin
      // An invalid EX slot must not become a MEM producer.
      r_mem_dst <= r_ex_dst;
      r_mem_we  <= r_ex_we & r_ex_valid;
      r_wb_dst  <= r_mem_dst;
      r_wb_we   <= r_mem_we;
      if (w_stall) begin
        r_ex_valid  <= 1'b0;
        r_ex_we     <= 1'b0;
        r_ex_mr     <= 1'b0;
        r_fwd_a_sel <= 2'b00;
        r_fwd_b_sel <= 2'b00;
        if (r_stall_count != '1)
          r_stall_count <= r_stall_count + STALL_CNT_W'(1);
      end else begin
        r_ex_valid  <= bus.id_valid;
        r_ex_rs     <= bus.id_rs;
        r_ex_rt     <= bus.id_rt;
        r_ex_dst    <= bus.id_dst;
        r_ex_we     <= bus.id_reg_write;
        r_ex_mr     <= bus.id_mem_read;
        r_fwd_a_sel <= w_next_a;
        r_fwd_b_sel <= w_next_b;
      end
    end
  end

  assign bus.fwd_a_sel   = r_fwd_a_sel;
  assign bus.fwd_b_sel   = r_fwd_b_sel;
  assign bus.stall       = w_stall;
  assign bus.stall_count = r_stall_count;

endmodule

// File: doc/forward_select_gen.md
# forward_select_gen

Pipelined forwarding and load-use hazard controller for the 5-stage MIPS datapath. It tracks the destination register, write-enable and load flag of each instruction in EX, MEM and WB. From these it produces registered 2-bit select codes for the two EX-stage 32-bit 4:1 operand multiplexers, plus a combinational stall request to the IF/ID stage. It is the driving end of the operand-mux select interface.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating stall counter.
- `clk`, in, 1: single clock; every register updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `freeze`, in, 1: global pipeline hold; all internal state holds when high.
- `id_valid`, in, 1: the ID stage holds a real instruction.
- `id_rs`, in, 5: rs field of the ID instruction.
- `id_rt`, in, 5: rt field of the ID instruction.
- `id_dst`, in, 5: resolved destination register of the ID instruction.
- `id_reg_write`, in, 1: the ID instruction writes the register file.
- `id_mem_read`, in, 1: the ID instruction is a load.
- `fwd_a_sel`, out, 2: operand A mux select for the instruction currently in EX.
- `fwd_b_sel`, out, 2: operand B mux select for the instruction currently in EX.
- `stall`, out, 1: load-use hazard; hold PC and IF/ID and insert a bubble into EX.
- `stall_count`, out, STALL_CNT_W: saturating count of stall cycles.

## Operation
- Select encoding matches the mux port order:
  - 00: register-file value (in1).
  - 01: MEM/WB result (in2).
  - 10: EX/MEM result (in3).
  - 11: never driven.
- Internal pipeline registers:
  - EX: `ex_valid`, `ex_rs`, `ex_rt`, `ex_dst`, `ex_we`, `ex_mr`.
  - MEM: `mem_dst`, `mem_we`.
  - WB: `wb_dst`, `wb_we`.
- A stage "writes r" when its `we` is 1, its `valid` is 1 (EX stage only), and `dst == r`, with r != 0.
- Next select for operand A is computed from `id_rs`; next select for operand B is computed the same way from `id_rt`:
  - 10 if the current EX stage writes the register (this instruction moves to MEM next cycle).
  - else 01 if the current MEM stage writes the register.
  - else 00.
- Priority: when both EX and MEM match, 10 wins (most recent producer).
- Register 0 never forwards; the select is always 00 for r = 0.
- `stall` = `id_valid & ex_valid & ex_mr & ex_we & (ex_dst != 0) & (ex_dst == id_rs | ex_dst == id_rt)`.
  - Purely combinational.
  - Asserted even while `freeze` is high.
- Advance (`freeze` = 0, `stall` = 0):
  - ID fields load into EX; `ex_valid` <= `id_valid`.
  - EX moves to MEM, MEM moves to WB.
  - `fwd_*_sel` load their next values.
- Stall (`freeze` = 0, `stall` = 1):
  - EX receives a bubble: `ex_valid` = 0, `ex_we` = 0, `ex_mr` = 0, `fwd_*_sel` = 00.
  - MEM and WB advance normally.
  - The ID instruction is re-presented next cycle by the upstream hold.
- Freeze: every register holds, including `stall_count`.
- `stall_count` increments by 1 on each non-frozen stall cycle and saturates at all-ones.
- WB registers are tracking-only. Register-file write-before-read covers WB hazards, so WB never produces a forward.

## Timing
- Reset (`rst_n` low, asynchronous): all pipeline registers, `fwd_a_sel`, `fwd_b_sel` and `stall_count` go to 0. Because `ex_valid` = 0, `stall` reads 0 during reset.
- Outputs immediately after reset release: selects 00, `stall` 0, count 0.
- Select latency: the value is computed during the ID cycle and registered on the edge that moves the instruction into EX. It is valid for the whole EX cycle.
- Stall is same-cycle combinational: exactly one stall cycle per load-use pair. After the bubble, the load sits in MEM, and the dependent instruction gets select 01 when it enters EX.
- Reset asserted mid-stall: all state clears, so `stall` falls combinationally.
- `rst_n` deasserts synchronously to `clk` (handled externally).

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: `add $3,$1,$2` followed by `sub $4,$3,$5`.
  - Required: in the sub's EX cycle, `fwd_a_sel` = 10 and `fwd_b_sel` = 00; `stall` stays 0.
- Distance-2 dependency:
  - Stimulus: producer of $7, one unrelated instruction, then a consumer using $7 as rt.
  - Required: consumer's EX cycle has `fwd_b_sel` = 01.
- Double match:
  - Stimulus: `$6` written by two consecutive instructions, then read as rs.
  - Required: `fwd_a_sel` = 10, never 01.
- Load-use:
  - Stimulus: `lw $8,0($1)` followed by `add $9,$8,$8`.
  - Required: `stall` = 1 for exactly one cycle; `stall_count` goes 0 to 1.
  - Required: then add's EX has both selects = 01.
- Register 0 and invalid instructions:
  - Stimulus: writer with dst $0 followed by a reader of $0.
  - Required: selects 00 and no stall.
  - Stimulus: `id_valid` = 0 load followed by a dependent instruction.
  - Required: no stall.
- Freeze and reset:
  - Stimulus: `freeze` = 1 for 3 cycles during a load-use.
  - Required: `stall` stays 1, selects and count hold.
  - Stimulus: `rst_n` pulse mid-stream.
  - Required: all outputs 0 asynchronously, before the next edge.
